// File: rtl/nbit_arith_pkg.sv
// Shared types and constants for the sequential N-bit arithmetic units (multiplier, divider).
// Latency: none, declarations only.
// Backpressure: not applicable.
package nbit_arith_pkg;

    // Controller state encoding shared with the shift-add multiplier
    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t CALC = 2'b01;
    localparam state_t DONE = 2'b10;

    // Iteration counter width: must hold the values 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nbit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into R, trial-subtract D, emit one quotient bit.
// Latency: purely combinational.
// Backpressure: none; the parent FSM decides when the result is registered.
module nbit_div_step #(
    parameter int N = 4
) (
    input  logic [N-1:0] r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] d,
    output logic [N-1:0] r_next,
    output logic [N-1:0] q_next
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // Trial subtraction. R < D always holds, so N+1 bits cover the shifted partial remainder.
    // The sign bit of diff shows whether the subtraction fits.
    always_comb begin
        shifted = {r, q[N-1]};
        diff    = shifted - {1'b0, d};
        if (!diff[N]) begin
            r_next = diff[N-1:0];
            q_next = {q[N-2:0], 1'b1};
        end else begin
            r_next = shifted[N-1:0];
            q_next = {q[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/nbit_divider.sv
// Sequential N-bit unsigned restoring divider with start/finish 4-phase handshake; divide-by-zero is flagged.
// Latency: finish high N+1 clocks after start is first sampled in IDLE, counting the sampling edge; 1 clock for divide-by-zero.
// Backpressure: the result is held in DONE while start stays high; a held start never relaunches.
module nbit_divider
    import nbit_arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         finish,
    output logic         busy,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  r_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  d_reg;
    logic [N-1:0]  r_next;
    logic [N-1:0]  q_next;

    nbit_div_step #(.N(N)) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (r_next),
        .q_next (q_next)
    );

    // Controller: latch operands, run N iterations, publish the result, then wait for start to drop.
    // The last iteration loads the outputs directly from the step result, so DONE is entered with no extra cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            finish      <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (b_in != '0) begin
                            q_reg <= a_in;
                            d_reg <= b_in;
                            r_reg <= '0;
                            cnt   <= '0;
                            state <= CALC;
                        end else begin
                            // Divide by zero: short-circuit to DONE with the conventional saturated result
                            quotient    <= '1;
                            remainder   <= a_in;
                            div_by_zero <= 1'b1;
                            finish      <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                CALC: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                        finish      <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        finish <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    finish <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
